// File: rtl/ssd_scan_driver_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package ssd_scan_driver_pkg;

    // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        B2B_IDLE,
        B2B_SHIFT,
        B2B_DONE
    } b2bState_t;

    // Ceiling log2; returns 0 for n<=1
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [6:0] segDecode(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = SEG_0;
            4'd1: s = SEG_1;
            4'd2: s = SEG_2;
            4'd3: s = SEG_3;
            4'd4: s = SEG_4;
            4'd5: s = SEG_5;
            4'd6: s = SEG_6;
            4'd7: s = SEG_7;
            4'd8: s = SEG_8;
            4'd9: s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ssd_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock.
// The bcd/ovf outputs only change on the final iteration, so a consumer
// never sees a half-converted value.
module ssd_bin2bcd
    import ssd_scan_driver_pkg::*;
#(
    parameter int DIGITS  = 8,
    parameter int VALUE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [VALUE_W-1:0]    value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (clog2(VALUE_W) > 0) ? clog2(VALUE_W) : 1;

    b2bState_t state, stateNext;

    logic [VALUE_W-1:0] binSh;
    logic [BW-1:0]      bcdSh, bcdAdj, bcdShifted;
    logic               ovfSh, ovfNext, lastIter;
    logic [CW-1:0]      iter;

    // Add 3 to every nibble >= 5, then shift in the next binary bit; a 1
    // leaving the top nibble means the value needs more digits than we have.
    always_comb begin
        bcdAdj = bcdSh;
        for (int n = 0; n < DIGITS; n++) begin
            if (bcdSh[4*n +: 4] >= 4'd5) bcdAdj[4*n +: 4] = bcdSh[4*n +: 4] + 4'd3;
        end
        bcdShifted = {bcdAdj[BW-2:0], binSh[VALUE_W-1]};
        ovfNext    = ovfSh | bcdAdj[BW-1];
        lastIter   = (iter == CW'(VALUE_W - 1));
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= B2B_IDLE;
        else          state <= stateNext;
    end

    // Sequencer: IDLE -> SHIFT x VALUE_W -> DONE -> IDLE (DONE also accepts)
    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            B2B_IDLE:  if (start) stateNext = B2B_SHIFT;
            B2B_SHIFT: begin
                busy = 1'b1;
                if (lastIter) stateNext = B2B_DONE;
            end
            B2B_DONE: begin
                done      = 1'b1;
                stateNext = start ? B2B_SHIFT : B2B_IDLE;
            end
            default:   stateNext = B2B_IDLE;
        endcase
    end

    // Working shift registers plus the atomically-updated result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            binSh <= '0;
            bcdSh <= '0;
            ovfSh <= 1'b0;
            iter  <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                B2B_SHIFT: begin
                    binSh <= binSh << 1;
                    bcdSh <= bcdShifted;
                    ovfSh <= ovfNext;
                    iter  <= iter + 1'b1;
                    if (lastIter) begin
                        bcd <= bcdShifted;
                        ovf <= ovfNext;
                    end
                end
                default: begin
                    if (start) begin
                        binSh <= value;
                        bcdSh <= '0;
                        ovfSh <= 1'b0;
                        iter  <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// N-digit seven-segment scan driver: binary value -> BCD -> multiplexed
// active-low anodes/segments with leading-zero blanking and overflow dashes.
module ssd_scan_driver
    import ssd_scan_driver_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int VALUE_W     = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    output logic               ready,
    input  logic               blank_lz,
    input  logic [DIGITS-1:0]  dp_in,
    output logic [DIGITS-1:0]  anode,
    output logic [6:0]         seg,
    output logic               dp
);

    localparam int PW = (clog2(REFRESH_DIV) > 0) ? clog2(REFRESH_DIV) : 1;
    localparam int IW = (clog2(DIGITS) > 0) ? clog2(DIGITS) : 1;

    logic                busy, done, ovf;
    logic [4*DIGITS-1:0] bcd;
    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic                tick;
    logic [DIGITS-1:0]   blankMask;
    logic                zeroRun;
    logic [3:0]          curNib;
    logic                curBlank, curDp;
    logic [6:0]          segNext;
    logic [DIGITS-1:0]   anodeNext;

    ssd_bin2bcd #(.DIGITS(DIGITS), .VALUE_W(VALUE_W)) uConv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (load && ready),
        .value   (value),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd),
        .ovf     (ovf)
    );

    // Loads are accepted whenever the converter is idle or just finishing
    assign ready = !busy || done;
    assign tick  = (presc == PW'(REFRESH_DIV - 1));

    // Digit-slot prescaler and scan index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                if (DIGITS == 1 || idx == IW'(DIGITS - 1)) idx <= '0;
                else                                       idx <= idx + 1'b1;
            end
        end
    end

    // Leading-zero mask (digit 0 never blanked) and current-digit select
    always_comb begin
        blankMask = '0;
        zeroRun   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zeroRun      = zeroRun && (bcd[4*i +: 4] == 4'd0);
            blankMask[i] = blank_lz && zeroRun && (i != 0);
        end
        curNib   = bcd[3:0];
        curBlank = blankMask[0];
        curDp    = dp_in[0];
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                curNib   = bcd[4*i +: 4];
                curBlank = blankMask[i];
                curDp    = dp_in[i];
            end
        end
        if (ovf)           segNext = SEG_DASH;
        else if (curBlank) segNext = SEG_BLANK;
        else               segNext = segDecode(curNib);
        anodeNext = ~(DIGITS'(1) << idx);
    end

    // Output registers: anode, segments and dp switch on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            anode <= '1;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
        end else begin
            anode <= anodeNext;
            seg   <= segNext;
            dp    <= ~curDp;
        end
    end

endmodule
